// File: rtl/servant_uart_rx.sv
// Oversampling UART receiver with a small byte FIFO and level interrupt for the servant SoC.
// Optional 8E1 framing is enabled by defining SERVANT_UART_RX_PARITY_EN (default build is 8N1).
module servant_uart_rx #(
    parameter int CLKS_PER_BIT = 556,
    parameter int DEPTH        = 4
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_vld,
    input  logic       i_rdy,
    output logic       o_irq,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

`ifdef SERVANT_UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q, rx_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        mem [DEPTH];

    logic tick, fall, full, push, pop, par_bad;

`ifdef SERVANT_UART_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    assign tick = (cnt_q == '0);
    assign fall = rx_q & ~rx_s_q;
    // Full is judged before any same-cycle pop, so push-at-full is always dropped.
    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) & i_rdy;

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? cnt_q : cnt_q - CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push        = 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        cnt_d     = FULL_BIT;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = FULL_BIT;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERVANT_UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_err_d = ^{rx_s_q, shift_q};
                    cnt_d     = FULL_BIT;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    if (!rx_s_q || par_bad) begin
                        frame_err_d = 1'b1;
                    end else if (full) begin
                        overrun_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_q        <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= i_rx;
            rx_s_q      <= rx_meta_q;
            rx_q        <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef SERVANT_UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // Storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign o_vld       = (count_q != '0);
    assign o_irq       = o_vld;
    assign o_data      = o_vld ? mem[rd_ptr_q] : 8'h00;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule
